imem_uart_loader: RTL and testbench

- Upstream boot stage for the single-cycle RISC-V core on FPGA: receives a program over UART and writes it word-by-word into the core's instruction memory.
- Holds the core in reset while loading, then releases it so execution starts at PC 0.
- Sits between the board UART RX pin and the instruction-memory write port and core reset input.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/uart_rx_8n1.sv | 105 ++++++++++
 rtl/imem_uart_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: FSM encoding, sync byte, bit timing.
// IMEM_LOADER_CHECKSUM_EN (optional) adds the S_CSUM trailer check in imem_uart_loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5,
    S_CSUM = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer, falling-edge start detect with mid-bit sampling.
// Emits a one-cycle rx_valid with rx_byte, or rx_ferr when the stop bit reads low.
module uart_rx_8n1 import loader_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             sync1_reg, sync2_reg, prev_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (prev_reg && !sync2_reg) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          // A line that is high again at mid start bit was only a glitch.
          state_next = sync2_reg ? RX_IDLE : RX_DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          valid_next = sync2_reg;
          ferr_next  = !sync2_reg;
          state_next = RX_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign rx_byte  = shift_reg;
  assign rx_valid = valid_reg;
  assign rx_ferr  = ferr_reg;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives A5, 16-bit word count, then little-endian words over UART and writes imem.
// Holds the core in reset until DONE. Define IMEM_LOADER_CHECKSUM_EN for the XOR trailer byte.
module imem_uart_loader import loader_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_8n1 #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  state_t            state_reg, state_next;
  logic [7:0]        len_lo_reg, len_lo_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W:0]   word_idx_reg, word_idx_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [31:0]       word_asm_reg, word_asm_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic [15:0] len_rx;
  logic        last_word;
  assign len_rx    = {rx_byte, len_lo_reg};
  assign last_word = (32'(word_idx_reg) + 32'd1) == 32'(len_reg);

  always_comb begin
    state_next      = state_reg;
    len_lo_next     = len_lo_reg;
    len_next        = len_reg;
    word_idx_next   = word_idx_reg;
    byte_idx_next   = byte_idx_reg;
    word_asm_next   = word_asm_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) state_next = S_LEN0;
      end
      S_LEN0: begin
        if (rx_ferr) state_next = S_ERR;
        else if (rx_valid) begin
          len_lo_next = rx_byte;
          state_next  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_ferr) state_next = S_ERR;
        else if (rx_valid) begin
          len_next      = len_rx;
          word_idx_next = '0;
          byte_idx_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next     = '0;
`endif
          if (len_rx == 16'd0)            state_next = S_TAIL;
          else if (32'(len_rx) > DEPTH)   state_next = S_ERR;
          else                            state_next = S_DATA;
        end
      end
      S_DATA: begin
        // The strobe cycle advances the word index; bytes are far apart so none is lost here.
        if (imem_we_reg) begin
          word_idx_next = word_idx_reg + 1'b1;
          if (last_word) state_next = S_TAIL;
        end else if (rx_ferr) begin
          state_next = S_ERR;
        end else if (rx_valid) begin
          word_asm_next[{byte_idx_reg, 3'b000} +: 8] = rx_byte;
          byte_idx_next = byte_idx_reg + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next     = csum_reg ^ rx_byte;
`endif
          if (byte_idx_reg == 2'd3) begin
            imem_we_next    = 1'b1;
            imem_addr_next  = word_idx_reg[ADDR_W-1:0];
            imem_wdata_next = word_asm_next;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ferr) state_next = S_ERR;
        else if (rx_valid) state_next = (rx_byte == csum_reg) ? S_DONE : S_ERR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      len_lo_reg     <= '0;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      byte_idx_reg   <= '0;
      word_asm_reg   <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      len_lo_reg     <= len_lo_next;
      len_reg        <= len_next;
      word_idx_reg   <= word_idx_next;
      byte_idx_reg   <= byte_idx_next;
      word_asm_reg   <= word_asm_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_rst    = (state_reg != S_DONE);
  assign load_done  = (state_reg == S_DONE);
  assign load_err   = (state_reg == S_ERR);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes are queued by stimulus, popped by a monitor.
// Runs the checksum-trailer cases when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_uart_loader;

  localparam int CLK_FREQ_HZ = 1843200;
  localparam int BAUD        = 115200;
  localparam int CPB         = 16;
  localparam int ADDR_W      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_rx = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst, load_done, load_err;

  imem_uart_loader #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] data_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_we_cyc = 0;
  int         fall_cyc = -100;
  logic       prev_cpu_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      last_we_cyc = cyc;
      $display("write addr=%0d data=%h", imem_addr, imem_wdata);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
      end
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    $display("tx byte=%h stop=%0b", b, stop_bit);
  endtask

  // Sends A5, count, data_q bytes, and (when enabled) the XOR trailer with flip applied.
  task automatic send_load(input logic [15:0] n, input logic [7:0] flip);
    logic [7:0] csum;
    csum = flip;
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    foreach (data_q[i]) begin
      send_byte(data_q[i], 1'b1);
      csum = csum ^ data_q[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, 1'b1);
`endif
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 400 && cpu_rst; i++) @(negedge clk);
    if (cpu_rst) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got cpu_rst=1 expected 0 within 400 cycles", name);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);

    repeat (2000) @(negedge clk);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("idle_load_done", 32'(load_done), 32'd0);

    // Quarter-bit glitch on the idle line must not frame a byte.
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_load_err", 32'(load_err), 32'd0);

    // Two-word program.
    push_exp(8'd0, 32'h00500513);
    push_exp(8'd1, 32'h00600593);
    data_q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
    send_load(16'd2, 8'h00);
    wait_done("two_words");
    check("two_words_done", 32'(load_done), 32'd1);
    check("two_words_cpu_rst", 32'(cpu_rst), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("cpu_rst_fall_delay", 32'(fall_cyc - last_we_cyc), 32'd1);
`endif
    check("two_words_drained", 32'(exp_q.size()), 32'd0);

    // Garbage is ignored, then a zero-length load restarts and finishes.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h13, 1'b1);
    check("garbage_done_kept", 32'(load_done), 32'd1);
    send_byte(8'hA5, 1'b1);
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_load_done", 32'(load_done), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    wait_done("zero_len");
    check("zero_len_done", 32'(load_done), 32'd1);

    // N = 257 exceeds the 256-word memory.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    check("too_long_err", 32'(load_err), 32'd1);
    check("too_long_cpu_rst", 32'(cpu_rst), 32'd1);
    check("too_long_done", 32'(load_done), 32'd0);

    push_exp(8'd0, 32'h00500513);
    data_q = '{8'h13, 8'h05, 8'h50, 8'h00};
    send_load(16'd1, 8'h00);
    wait_done("recover");
    check("recover_err_clear", 32'(load_err), 32'd0);
    check("recover_done", 32'(load_done), 32'd1);

    // Framing error inside DATA.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b0);
    repeat (CPB) @(negedge clk);
    check("ferr_err", 32'(load_err), 32'd1);
    check("ferr_cpu_rst", 32'(cpu_rst), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct words but a wrong trailer: 0x47 against 0x46.
    push_exp(8'd0, 32'h00500513);
    data_q = '{8'h13, 8'h05, 8'h50, 8'h00};
    send_load(16'd1, 8'h01);
    repeat (CPB) @(negedge clk);
    check("csum_bad_err", 32'(load_err), 32'd1);
    check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
`endif

    // Asynchronous reset in the middle of a word.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    check("midword_err_clear", 32'(load_err), 32'd0);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("async_rst_we", 32'(imem_we), 32'd0);
    check("async_rst_addr", 32'(imem_addr), 32'd0);
    check("async_rst_wdata", imem_wdata, 32'd0);
    check("async_rst_done", 32'(load_done), 32'd0);
    check("async_rst_err", 32'(load_err), 32'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    push_exp(8'd0, 32'hDEADBEEF);
    data_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_load(16'd1, 8'h00);
    wait_done("after_rst");
    check("after_rst_done", 32'(load_done), 32'd1);

    repeat (20) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
